// File: rtl/sram_bank_ctrl_pkg.sv
// rtl/sram_bank_ctrl_pkg.sv - FSM encoding, pin-intent struct and sizing helpers for sram_bank_ctrl
package sram_bank_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACT,
    S_RD_WAIT,
    S_RD_CAP,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  // Active-high intent for the addressed bank; the port converts to pin polarity.
  typedef struct packed {
    logic ce;
    logic oe;
    logic we;
    logic drive;
  } pin_ctrl_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int bank_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/sram_bank_ctrl_port.sv
// rtl/sram_bank_ctrl_port.sv - registered pin set for one SRAM chip
module sram_bank_ctrl_port
  import sram_bank_ctrl_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  pin_ctrl_t           ctrl,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_dq_o,
  output logic                sram_dq_t,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [DATA_W/8-1:0] sram_be_n
);

  logic act;
  assign act = sel & ctrl.ce;

  // Address and write data only move while this bank is addressed, so idle banks hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sram_addr <= '0;
      sram_dq_o <= '0;
      sram_dq_t <= 1'b1;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
    end else begin
      sram_ce_n <= ~act;
      sram_oe_n <= ~(act & ctrl.oe);
      sram_we_n <= ~(act & ctrl.we);
      sram_dq_t <= ~(act & ctrl.drive);
      sram_be_n <= act ? ~be : '1;
      if (act) sram_addr <= addr;
      if (act & ctrl.drive) sram_dq_o <= wdata;
    end
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// rtl/sram_bank_ctrl.sv - banked async-SRAM controller top; define SRAM_BYTE_STROBE_EN for byte-masked writes
module sram_bank_ctrl
  import sram_bank_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int BANKS   = 2,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  localparam int SEL_W  = $clog2(BANKS),
  localparam int BANK_W = bank_w(BANKS),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     we,
  input  logic [ADDR_W+SEL_W-1:0]  addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [STRB_W-1:0]        wstrb,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ack,
  output logic                     busy,
  output logic                     drop,
  output logic [BANKS*ADDR_W-1:0]  sram_addr,
  output logic [BANKS*DATA_W-1:0]  sram_dq_o,
  input  logic [BANKS*DATA_W-1:0]  sram_dq_i,
  output logic [BANKS-1:0]         sram_dq_t,
  output logic [BANKS-1:0]         sram_ce_n,
  output logic [BANKS-1:0]         sram_oe_n,
  output logic [BANKS-1:0]         sram_we_n,
  output logic [BANKS*STRB_W-1:0]  sram_be_n
);

  localparam int CNT_W   = $clog2(max_int(RD_WAIT, WR_WAIT) + 2);
  localparam int RD_LOAD = (RD_WAIT > 0) ? RD_WAIT - 1 : 0;

  if (BANKS < 1 || (BANKS & (BANKS - 1)) != 0) begin : g_bad_banks
    $error("BANKS must be a power of two >= 1");
  end
  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if (RD_WAIT < 0 || RD_WAIT > 15 || WR_WAIT < 0 || WR_WAIT > 15) begin : g_bad_wait
    $error("RD_WAIT/WR_WAIT must be 0..15");
  end

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic [BANK_W-1:0]  live_bank, cmd_bank, nx_bank;
  logic [ADDR_W-1:0]  cmd_addr, nx_addr;
  logic [DATA_W-1:0]  cmd_wdata, nx_wdata;
  logic [STRB_W-1:0]  cmd_wstrb, nx_wstrb, wr_lanes, be_lanes;
  pin_ctrl_t          ctrl;

  assign accept = (state == S_IDLE) && req;

  if (BANKS > 1) begin : g_bank_sel
    assign live_bank = addr[ADDR_W +: SEL_W];
  end else begin : g_single_bank
    assign live_bank = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_bank  <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_wstrb <= '0;
    end else if (accept) begin
      cmd_bank  <= live_bank;
      cmd_addr  <= addr[ADDR_W-1:0];
      cmd_wdata <= wdata;
      cmd_wstrb <= wstrb;
    end
  end

  // Pins are registered from the next state, so the accept cycle must see the live command.
  assign nx_bank  = accept ? live_bank         : cmd_bank;
  assign nx_addr  = accept ? addr[ADDR_W-1:0]  : cmd_addr;
  assign nx_wdata = accept ? wdata             : cmd_wdata;
  assign nx_wstrb = accept ? wstrb             : cmd_wstrb;

`ifdef SRAM_BYTE_STROBE_EN
  assign wr_lanes = nx_wstrb;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^nx_wstrb;
  assign wr_lanes     = '1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (req) state_nx = we ? S_WR_SETUP : S_RD_ACT;
      S_RD_ACT:   state_nx = (RD_WAIT == 0) ? S_RD_CAP : S_RD_WAIT;
      S_RD_WAIT:  if (cnt == '0) state_nx = S_RD_CAP;
      S_RD_CAP:   state_nx = S_IDLE;
      S_WR_SETUP: state_nx = S_WR_PULSE;
      S_WR_PULSE: if (cnt == '0) state_nx = S_WR_HOLD;
      S_WR_HOLD:  state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl     = '0;
    be_lanes = '1;
    case (state_nx)
      S_RD_ACT, S_RD_WAIT, S_RD_CAP: begin
        ctrl.ce = 1'b1;
        ctrl.oe = 1'b1;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ctrl.ce    = 1'b1;
        ctrl.drive = 1'b1;
        be_lanes   = wr_lanes;
      end
      S_WR_PULSE: begin
        ctrl.ce    = 1'b1;
        ctrl.drive = 1'b1;
        ctrl.we    = |wr_lanes;
        be_lanes   = wr_lanes;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state_nx != state) begin
      case (state_nx)
        S_RD_WAIT:  cnt <= CNT_W'(RD_LOAD);
        S_WR_PULSE: cnt <= CNT_W'(WR_WAIT);
        default:    cnt <= '0;
      endcase
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= (state == S_RD_CAP) || (state == S_WR_HOLD);
      if (state == S_RD_CAP) rdata <= sram_dq_i[int'(cmd_bank) * DATA_W +: DATA_W];
    end
  end

  assign busy = (state != S_IDLE);
  assign drop = req & busy;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    sram_bank_ctrl_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
      .clk       (clk),
      .rst       (rst),
      .sel       (nx_bank == BANK_W'(b)),
      .ctrl      (ctrl),
      .addr      (nx_addr),
      .wdata     (nx_wdata),
      .be        (be_lanes),
      .sram_addr (sram_addr[b*ADDR_W +: ADDR_W]),
      .sram_dq_o (sram_dq_o[b*DATA_W +: DATA_W]),
      .sram_dq_t (sram_dq_t[b]),
      .sram_ce_n (sram_ce_n[b]),
      .sram_oe_n (sram_oe_n[b]),
      .sram_we_n (sram_we_n[b]),
      .sram_be_n (sram_be_n[b*STRB_W +: STRB_W])
    );
  end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb/tb_sram_bank_ctrl.sv - directed bench for sram_bank_ctrl (BANKS=2, RD_WAIT=1, WR_WAIT=2)
module tb_sram_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [20:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ack, busy, drop;
  logic [39:0] sram_addr;
  logic [63:0] sram_dq_o, sram_dq_i;
  logic [1:0]  sram_dq_t, sram_ce_n, sram_oe_n, sram_we_n;
  logic [7:0]  sram_be_n;

  int n_pass = 0;
  int n_total = 0;

`ifdef SRAM_BYTE_STROBE_EN
  localparam logic [31:0] EXP_ZERO_STRB = 32'h5566_7788;
  localparam logic [31:0] EXP_PARTIAL   = 32'h11BB_33DD;
  localparam int          WL_ZERO_STRB  = 0;
`else
  localparam logic [31:0] EXP_ZERO_STRB = 32'h0BAD_F00D;
  localparam logic [31:0] EXP_PARTIAL   = 32'hAABB_CCDD;
  localparam int          WL_ZERO_STRB  = 3;
`endif

  always #5 clk = ~clk;

  sram_bank_ctrl #(.ADDR_W(20), .DATA_W(32), .BANKS(2), .RD_WAIT(1), .WR_WAIT(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ack(ack), .busy(busy), .drop(drop),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_t(sram_dq_t),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  // Two small SRAM chips indexed by the low 8 address bits.
  logic [31:0] mem [2][256];

  always_comb begin
    for (int b = 0; b < 2; b++)
      sram_dq_i[b*32 +: 32] = (!sram_ce_n[b] && !sram_oe_n[b]) ? mem[b][sram_addr[b*20 +: 8]] : 32'h0;
  end

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++)
      if (!sram_ce_n[b] && !sram_we_n[b])
        for (int k = 0; k < 4; k++)
          if (!sram_be_n[b*4+k]) mem[b][sram_addr[b*20 +: 8]][k*8 +: 8] = sram_dq_o[b*32+k*8 +: 8];
  end

  typedef struct {
    string       name;
    logic        we;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_we_low;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic run_txn(input logic twe, input logic [20:0] ta, input logic [31:0] twd,
                         input logic [3:0] tst, output int lat, output int we_low,
                         output int other_ce, output int dq_bad);
    int b;
    b = int'(ta[20]);
    @(negedge clk);
    req = 1'b1; we = twe; addr = ta; wdata = twd; wstrb = tst;
    @(posedge clk); #1 req = 1'b0;
    lat = 0; we_low = 0; other_ce = 0; dq_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!sram_we_n[b]) we_low++;
      if (!sram_ce_n[1-b]) other_ce++;
      if (!sram_dq_t[b] && sram_dq_o[b*32 +: 32] !== twd) dq_bad++;
    end while (!ack && lat < 40);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int lat, wl, oc, db, acks, n;

    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) mem[b][i] = 32'h0;
    mem[1][8'h05] = 32'hDEAD_BEEF;
    mem[0][8'h05] = 32'h0F0F_0F0F;
    mem[0][8'h20] = 32'hCAFE_F00D;
    mem[0][8'h30] = 32'h5566_7788;
    mem[0][8'h40] = 32'h1122_3344;

    vecs[0] = '{"rd_b1_5",      1'b0, 21'h100005, 32'h0,          4'hF, 32'hDEAD_BEEF, 4, 0};
    vecs[1] = '{"wr_b0_10",     1'b1, 21'h000010, 32'hA5A5_5A5A,  4'hF, 32'h0,         6, 3};
    vecs[2] = '{"rd_b0_10",     1'b0, 21'h000010, 32'h0,          4'hF, 32'hA5A5_5A5A, 4, 0};
    vecs[3] = '{"wr_b1_20",     1'b1, 21'h100020, 32'h1234_5678,  4'hF, 32'h0,         6, 3};
    vecs[4] = '{"rd_b1_20",     1'b0, 21'h100020, 32'h0,          4'hF, 32'h1234_5678, 4, 0};
    vecs[5] = '{"rd_b0_20",     1'b0, 21'h000020, 32'h0,          4'hF, 32'hCAFE_F00D, 4, 0};
    vecs[6] = '{"wr_strb0",     1'b1, 21'h000030, 32'h0BAD_F00D,  4'h0, 32'h0,         6, WL_ZERO_STRB};
    vecs[7] = '{"rd_strb0",     1'b0, 21'h000030, 32'h0,          4'hF, EXP_ZERO_STRB, 4, 0};
    vecs[8] = '{"wr_strb0101",  1'b1, 21'h000040, 32'hAABB_CCDD,  4'h5, 32'h0,         6, 3};
    vecs[9] = '{"rd_strb0101",  1'b0, 21'h000040, 32'h0,          4'hF, EXP_PARTIAL,   4, 0};

    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ack",   64'(ack), 64'(0));
    chk("reset_busy",  64'(busy), 64'(0));
    chk("reset_ce_n",  64'(sram_ce_n), 64'(2'b11));
    chk("reset_we_n",  64'(sram_we_n), 64'(2'b11));
    chk("reset_dq_t",  64'(sram_dq_t), 64'(2'b11));
    chk("reset_be_n",  64'(sram_be_n), 64'(8'hFF));
    chk("reset_addr",  64'(sram_addr), 64'(0));
    chk("reset_rdata", 64'(rdata), 64'(0));
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat, wl, oc, db);
      chk({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].exp_lat));
      chk({vecs[i].name, "_other_bank_ce"}, 64'(oc), 64'(0));
      if (vecs[i].we) begin
        chk({vecs[i].name, "_we_low_cycles"}, 64'(wl), 64'(vecs[i].exp_we_low));
        chk({vecs[i].name, "_dq_stable"}, 64'(db), 64'(0));
      end else begin
        chk({vecs[i].name, "_rdata"}, 64'(rdata), 64'(vecs[i].exp_rd));
      end
    end

    // Requests while busy are dropped and never start a transaction.
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 21'h000020;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk); req = 1'b1; we = 1'b1; addr = 21'h100070; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    #1 chk("drop_first", 64'(drop), 64'(1));
    @(negedge clk); req = 1'b0;
    #1 chk("drop_gap", 64'(drop), 64'(0));
    @(negedge clk); req = 1'b1;
    #1 chk("drop_second", 64'(drop), 64'(1));
    @(negedge clk); req = 1'b0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (ack) acks++;
      @(negedge clk);
    end
    chk("drop_single_ack", 64'(acks), 64'(1));
    chk("drop_rdata", 64'(rdata), 64'(32'hCAFE_F00D));
    chk("drop_no_write", 64'(mem[1][8'h70]), 64'(0));
    chk("drop_idle_busy", 64'(busy), 64'(0));

    // A request in the ack cycle is accepted with no gap.
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 21'h100005;
    @(posedge clk); #1 req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 40);
    chk("b2b_first_latency", 64'(n), 64'(4));
    chk("b2b_ack_cycle_busy", 64'(busy), 64'(0));
    req = 1'b1; we = 1'b0; addr = 21'h000010;
    #1 chk("b2b_no_drop", 64'(drop), 64'(0));
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("b2b_accepted", 64'(busy), 64'(1));
    n = 1;
    while (!ack && n < 40) begin @(negedge clk); n++; end
    chk("b2b_second_latency", 64'(n), 64'(4));
    chk("b2b_second_rdata", 64'(rdata), 64'(32'hA5A5_5A5A));

    // Changing the bank bit after accept must not move the transaction.
    @(negedge clk); req = 1'b1; we = 1'b1; addr = 21'h100050; wdata = 32'h600D_CAFE; wstrb = 4'hF;
    @(posedge clk); #1 req = 1'b0; addr = 21'h000050;
    n = 0; oc = 0;
    do begin
      @(negedge clk); n++;
      if (!sram_ce_n[0] || !sram_we_n[0]) oc++;
    end while (!ack && n < 40);
    chk("latch_wr_latency", 64'(n), 64'(6));
    chk("latch_bank0_quiet", 64'(oc), 64'(0));
    run_txn(1'b0, 21'h100050, 32'h0, 4'hF, lat, wl, oc, db);
    chk("latch_rd_bank1", 64'(rdata), 64'(32'h600D_CAFE));
    run_txn(1'b0, 21'h000050, 32'h0, 4'hF, lat, wl, oc, db);
    chk("latch_rd_bank0", 64'(rdata), 64'(0));

    // Reset held in the middle of the write pulse aborts without an ack.
    @(negedge clk); req = 1'b1; we = 1'b1; addr = 21'h000060; wdata = 32'h1357_9BDF; wstrb = 4'hF;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_we_low_before", 64'(sram_we_n[0]), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_we_n", 64'(sram_we_n), 64'(2'b11));
    chk("abort_dq_t", 64'(sram_dq_t), 64'(2'b11));
    chk("abort_ce_n", 64'(sram_ce_n), 64'(2'b11));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_ack",  64'(ack), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("abort_no_ack", 64'(acks), 64'(0));
    run_txn(1'b0, 21'h100005, 32'h0, 4'hF, lat, wl, oc, db);
    chk("abort_recover_latency", 64'(lat), 64'(4));
    chk("abort_recover_rdata", 64'(rdata), 64'(32'hDEAD_BEEF));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
